// File: rtl/int_rename_rat_if.sv
// Rename-stage bus: decoded-instruction input, free-queue port, renamed output and commit port.
// The RAT is the slave; whoever drives decode, the free queue and commit is the master.
interface int_rename_rat_if #(
    parameter int PTAG_W = 5
);
    logic              InValid;
    logic              InReady;
    logic [4:0]        InRj;
    logic [4:0]        InRk;
    logic [4:0]        InRd;
    logic              InRdWe;

    logic              FreeEmpty;
    logic [PTAG_W-1:0] FreePreOut;
    logic              FreeRable;
    logic              FreeWable;
    logic [PTAG_W-1:0] FreeDin;
    logic              FreeClean;

    logic              OutValid;
    logic              OutReady;
    logic [PTAG_W-1:0] OutPj;
    logic [PTAG_W-1:0] OutPk;
    logic [PTAG_W-1:0] OutPd;
    logic [PTAG_W-1:0] OutOldPd;
    logic              OutRdWe;

    logic              CmtValid;
    logic              CmtRdWe;
    logic [4:0]        CmtRd;
    logic [PTAG_W-1:0] CmtPd;
    logic [PTAG_W-1:0] CmtOldPd;

    logic              Flush;

    modport slave (
        input  InValid, InRj, InRk, InRd, InRdWe,
        input  FreeEmpty, FreePreOut,
        input  OutReady,
        input  CmtValid, CmtRdWe, CmtRd, CmtPd, CmtOldPd,
        input  Flush,
        output InReady,
        output FreeRable, FreeWable, FreeDin, FreeClean,
        output OutValid, OutPj, OutPk, OutPd, OutOldPd, OutRdWe
    );

    modport master (
        output InValid, InRj, InRk, InRd, InRdWe,
        output FreeEmpty, FreePreOut,
        output OutReady,
        output CmtValid, CmtRdWe, CmtRd, CmtPd, CmtOldPd,
        output Flush,
        input  InReady,
        input  FreeRable, FreeWable, FreeDin, FreeClean,
        input  OutValid, OutPj, OutPk, OutPd, OutOldPd, OutRdWe
    );
endinterface

// File: rtl/int_rename_rat.sv
// Single-issue integer rename: speculative (SRAT) and committed (ARAT) map tables,
// free-queue allocation at rename, tag release at commit, SRAT recovery on flush.
module int_rename_rat #(
    parameter int PTAG_W = 5,
    parameter int AREG_N = 32
) (
    input  logic           Clk,
    input  logic           Rest,
    int_rename_rat_if.slave bus
);
    typedef logic [PTAG_W-1:0] tag_t;

    tag_t srat_q [AREG_N];
    tag_t srat_d [AREG_N];
    tag_t arat_q [AREG_N];
    tag_t arat_d [AREG_N];

    logic out_valid_q, out_valid_d;
    tag_t out_pj_q, out_pk_q, out_pd_q, out_old_pd_q;
    logic out_rd_we_q;

    logic need_alloc;
    logic cmt_we;
    logic in_ready;
    logic fire;

    // NOTE: combinational outputs are qualified with Rest so nothing pulses the free queue during reset.
    always_comb begin
        need_alloc = bus.InRdWe && (bus.InRd != 5'd0);
        cmt_we     = bus.CmtValid && bus.CmtRdWe && (bus.CmtRd != 5'd0);
        in_ready   = Rest && !bus.Flush && (!out_valid_q || bus.OutReady)
                     && (!need_alloc || !bus.FreeEmpty);
        fire       = bus.InValid && in_ready;
    end

    assign bus.InReady   = in_ready;
    assign bus.FreeRable = fire && need_alloc;
    assign bus.FreeWable = Rest && cmt_we && !bus.Flush;
    assign bus.FreeDin   = (Rest && cmt_we && !bus.Flush) ? bus.CmtOldPd : '0;
    assign bus.FreeClean = Rest && bus.Flush;

    assign bus.OutValid  = out_valid_q;
    assign bus.OutPj     = out_pj_q;
    assign bus.OutPk     = out_pk_q;
    assign bus.OutPd     = out_pd_q;
    assign bus.OutOldPd  = out_old_pd_q;
    assign bus.OutRdWe   = out_rd_we_q;

    // Flush copies the post-commit ARAT, so a commit landing with the flush is not lost.
    always_comb begin
        arat_d = arat_q;
        if (cmt_we) arat_d[bus.CmtRd] = bus.CmtPd;

        srat_d = srat_q;
        if (bus.Flush) begin
            srat_d = arat_d;
        end else if (fire && need_alloc) begin
            srat_d[bus.InRd] = bus.FreePreOut;
        end
    end

    always_comb begin
        out_valid_d = out_valid_q;
        if (bus.Flush) begin
            out_valid_d = 1'b0;
        end else if (fire) begin
            out_valid_d = 1'b1;
        end else if (bus.OutReady) begin
            out_valid_d = 1'b0;
        end
    end

    // NOTE: the map tables are reset to identity because that mapping is architectural state, not scratch storage.
    always_ff @(posedge Clk or negedge Rest) begin
        if (!Rest) begin
            for (int i = 0; i < AREG_N; i++) begin
                srat_q[i] <= tag_t'(i);
                arat_q[i] <= tag_t'(i);
            end
        end else begin
            srat_q <= srat_d;
            arat_q <= arat_d;
        end
    end

    // Sources and old destination read srat_q, i.e. the mapping before this cycle's allocation.
    always_ff @(posedge Clk or negedge Rest) begin
        if (!Rest) begin
            out_valid_q  <= 1'b0;
            out_pj_q     <= '0;
            out_pk_q     <= '0;
            out_pd_q     <= '0;
            out_old_pd_q <= '0;
            out_rd_we_q  <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            if (fire) begin
                out_pj_q     <= srat_q[bus.InRj];
                out_pk_q     <= srat_q[bus.InRk];
                out_old_pd_q <= srat_q[bus.InRd];
                out_pd_q     <= need_alloc ? bus.FreePreOut : '0;
                out_rd_we_q  <= need_alloc;
            end
        end
    end
endmodule

// File: tb/tb_int_rename_rat.sv
// Directed bench for int_rename_rat: expected renamed packets are queued when an
// instruction is accepted and compared when the output handshake completes.
module tb_int_rename_rat;
    typedef struct packed {
        logic [4:0] pj;
        logic [4:0] pk;
        logic [4:0] pd;
        logic [4:0] old;
        logic       we;
    } exp_t;

    logic clk = 1'b0;
    logic rest = 1'b0;
    int   tests = 0;
    int   failures = 0;
    exp_t sb [$];

    always #5 clk = ~clk;

    int_rename_rat_if #(.PTAG_W(5)) bus ();

    int_rename_rat #(.PTAG_W(5), .AREG_N(32)) dut (
        .Clk  (clk),
        .Rest (rest),
        .bus  (bus)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        bus.InValid    = 1'b0;
        bus.InRj       = '0;
        bus.InRk       = '0;
        bus.InRd       = '0;
        bus.InRdWe     = 1'b0;
        bus.FreeEmpty  = 1'b0;
        bus.FreePreOut = '0;
        bus.OutReady   = 1'b1;
        bus.CmtValid   = 1'b0;
        bus.CmtRdWe    = 1'b0;
        bus.CmtRd      = '0;
        bus.CmtPd      = '0;
        bus.CmtOldPd   = '0;
        bus.Flush      = 1'b0;
    endtask

    task automatic drive(input logic v, input logic [4:0] rj, input logic [4:0] rk,
                         input logic [4:0] rd, input logic we, input logic [4:0] pre);
        bus.InValid    = v;
        bus.InRj       = rj;
        bus.InRk       = rk;
        bus.InRd       = rd;
        bus.InRdWe     = we;
        bus.FreePreOut = pre;
        #1;
    endtask

    task automatic push(input logic [4:0] pj, input logic [4:0] pk, input logic [4:0] pd,
                        input logic [4:0] old, input logic we);
        exp_t e;
        e.pj = pj; e.pk = pk; e.pd = pd; e.old = old; e.we = we;
        sb.push_back(e);
    endtask

    // Sample the output handshake just before the rising edge, then move to the next falling edge.
    task automatic tick();
        exp_t e;
        #2;
        if (bus.OutValid && bus.OutReady) begin
            if (sb.size() == 0) begin
                check("sb_unexpected_output", 32'(bus.OutValid), 32'd0);
            end else begin
                e = sb.pop_front();
                check("out_pj",     32'(bus.OutPj),    32'(e.pj));
                check("out_pk",     32'(bus.OutPk),    32'(e.pk));
                check("out_pd",     32'(bus.OutPd),    32'(e.pd));
                check("out_old_pd", 32'(bus.OutOldPd), 32'(e.old));
                check("out_rd_we",  32'(bus.OutRdWe),  32'(e.we));
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset with aggressive inputs: nothing may pulse the free queue.
        idle();
        bus.Flush = 1'b1; bus.CmtValid = 1'b1; bus.CmtRdWe = 1'b1; bus.CmtRd = 5'd3;
        bus.CmtOldPd = 5'd3;
        drive(1'b1, 5'd1, 5'd2, 5'd5, 1'b1, 5'd9);
        check("rst_free_rable", 32'(bus.FreeRable), 32'd0);
        check("rst_free_wable", 32'(bus.FreeWable), 32'd0);
        check("rst_free_clean", 32'(bus.FreeClean), 32'd0);
        check("rst_out_valid",  32'(bus.OutValid),  32'd0);
        check("rst_out_pd",     32'(bus.OutPd),     32'd0);
        check("rst_out_old_pd", 32'(bus.OutOldPd),  32'd0);
        check("rst_out_rd_we",  32'(bus.OutRdWe),   32'd0);
        @(negedge clk);
        @(negedge clk);
        idle();
        rest = 1'b1;

        // First rename: r3 <- r1, r2 allocates 9.
        drive(1'b1, 5'd1, 5'd2, 5'd3, 1'b1, 5'd9);
        check("first_in_ready",   32'(bus.InReady),   32'd1);
        check("first_free_rable", 32'(bus.FreeRable), 32'd1);
        push(5'd1, 5'd2, 5'd9, 5'd3, 1'b1);
        tick();

        // Flush beats a ready instruction; SRAT returns to identity.
        bus.Flush = 1'b1;
        drive(1'b1, 5'd0, 5'd0, 5'd5, 1'b1, 5'd20);
        check("flush_out_valid_before", 32'(bus.OutValid),  32'd1);
        check("flush_in_ready",         32'(bus.InReady),   32'd0);
        check("flush_free_rable",       32'(bus.FreeRable), 32'd0);
        check("flush_free_clean",       32'(bus.FreeClean), 32'd1);
        tick();
        bus.Flush = 1'b0;

        // Back-to-back: add r3 <- r3, r3 (9), then sub r4 <- r3, r0 (13).
        drive(1'b1, 5'd3, 5'd3, 5'd3, 1'b1, 5'd9);
        check("flush_out_valid_after", 32'(bus.OutValid), 32'd0);
        check("b2b_a_in_ready",        32'(bus.InReady),  32'd1);
        push(5'd3, 5'd3, 5'd9, 5'd3, 1'b1);
        tick();
        drive(1'b1, 5'd3, 5'd0, 5'd4, 1'b1, 5'd13);
        check("b2b_b_in_ready", 32'(bus.InReady), 32'd1);
        push(5'd9, 5'd0, 5'd13, 5'd4, 1'b1);
        tick();

        // Rd=0 write renames even with an empty free queue and pops nothing.
        bus.FreeEmpty = 1'b1;
        drive(1'b1, 5'd4, 5'd3, 5'd0, 1'b1, 5'd0);
        check("r0_in_ready",   32'(bus.InReady),   32'd1);
        check("r0_free_rable", 32'(bus.FreeRable), 32'd0);
        push(5'd13, 5'd9, 5'd0, 5'd0, 1'b0);
        tick();

        // Empty queue stalls a real destination.
        drive(1'b1, 5'd1, 5'd2, 5'd5, 1'b1, 5'd21);
        check("empty_in_ready_0",   32'(bus.InReady),   32'd0);
        check("empty_free_rable_0", 32'(bus.FreeRable), 32'd0);
        tick();
        drive(1'b1, 5'd1, 5'd2, 5'd5, 1'b1, 5'd21);
        check("empty_in_ready_1", 32'(bus.InReady),  32'd0);
        check("drained_out_valid", 32'(bus.OutValid), 32'd0);
        tick();
        bus.FreeEmpty = 1'b0;
        drive(1'b1, 5'd1, 5'd2, 5'd5, 1'b1, 5'd21);
        check("refill_in_ready",   32'(bus.InReady),   32'd1);
        check("refill_free_rable", 32'(bus.FreeRable), 32'd1);
        push(5'd1, 5'd2, 5'd21, 5'd5, 1'b1);
        tick();

        // Downstream stall for three cycles: output held, input blocked.
        bus.OutReady = 1'b0;
        for (int c = 0; c < 3; c++) begin
            drive(1'b1, 5'd5, 5'd0, 5'd6, 1'b1, 5'd22);
            check("stall_out_valid",  32'(bus.OutValid),  32'd1);
            check("stall_out_pd",     32'(bus.OutPd),     32'd21);
            check("stall_out_old_pd", 32'(bus.OutOldPd),  32'd5);
            check("stall_out_pj",     32'(bus.OutPj),     32'd1);
            check("stall_in_ready",   32'(bus.InReady),   32'd0);
            check("stall_free_rable", 32'(bus.FreeRable), 32'd0);
            tick();
        end
        bus.OutReady = 1'b1;
        drive(1'b1, 5'd5, 5'd0, 5'd6, 1'b1, 5'd22);
        check("unstall_in_ready", 32'(bus.InReady), 32'd1);
        push(5'd21, 5'd0, 5'd22, 5'd6, 1'b1);
        tick();

        // Commit r3 -> 9 releases 3; rename alongside still reads speculative 9.
        bus.CmtValid = 1'b1; bus.CmtRdWe = 1'b1; bus.CmtRd = 5'd3;
        bus.CmtPd = 5'd9; bus.CmtOldPd = 5'd3;
        drive(1'b1, 5'd3, 5'd7, 5'd0, 1'b0, 5'd0);
        check("cmt_free_wable", 32'(bus.FreeWable), 32'd1);
        check("cmt_free_din",   32'(bus.FreeDin),   32'd3);
        check("cmt_in_ready",   32'(bus.InReady),   32'd1);
        push(5'd9, 5'd7, 5'd0, 5'd0, 1'b0);
        tick();
        bus.CmtRd = 5'd0; bus.CmtPd = 5'd12; bus.CmtOldPd = 5'd11;
        drive(1'b1, 5'd3, 5'd3, 5'd0, 1'b0, 5'd0);
        check("cmt_r0_free_wable", 32'(bus.FreeWable), 32'd0);
        check("cmt_r0_free_din",   32'(bus.FreeDin),   32'd0);
        push(5'd9, 5'd9, 5'd0, 5'd0, 1'b0);
        tick();
        bus.CmtValid = 1'b0; bus.CmtRdWe = 1'b0;
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 5'd0);
        tick();

        // Rename r7 -> 17, commit r3 -> 9 and flush together.
        bus.Flush = 1'b1;
        bus.CmtValid = 1'b1; bus.CmtRdWe = 1'b1; bus.CmtRd = 5'd3;
        bus.CmtPd = 5'd9; bus.CmtOldPd = 5'd3;
        drive(1'b1, 5'd7, 5'd3, 5'd7, 1'b1, 5'd17);
        check("fc_free_clean", 32'(bus.FreeClean), 32'd1);
        check("fc_free_wable", 32'(bus.FreeWable), 32'd0);
        check("fc_in_ready",   32'(bus.InReady),   32'd0);
        check("fc_free_rable", 32'(bus.FreeRable), 32'd0);
        tick();
        idle();
        drive(1'b1, 5'd3, 5'd7, 5'd0, 1'b0, 5'd0);
        check("fc_out_valid", 32'(bus.OutValid), 32'd0);
        push(5'd9, 5'd7, 5'd0, 5'd0, 1'b0);
        tick();
        drive(1'b1, 5'd4, 5'd5, 5'd0, 1'b0, 5'd0);
        push(5'd4, 5'd5, 5'd0, 5'd0, 1'b0);
        tick();

        // Mid-operation reset discards the in-flight output and restores identity.
        drive(1'b1, 5'd3, 5'd0, 5'd8, 1'b1, 5'd30);
        push(5'd9, 5'd0, 5'd30, 5'd8, 1'b1);
        tick();
        bus.OutReady = 1'b0;
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 5'd0);
        check("pre_rst_out_valid", 32'(bus.OutValid), 32'd1);
        rest = 1'b0;
        #1;
        check("mid_rst_out_valid", 32'(bus.OutValid), 32'd0);
        check("mid_rst_out_pd",    32'(bus.OutPd),    32'd0);
        check("mid_rst_out_rd_we", 32'(bus.OutRdWe),  32'd0);
        sb.delete();
        tick();
        rest = 1'b1;
        bus.OutReady = 1'b1;
        drive(1'b1, 5'd3, 5'd8, 5'd0, 1'b0, 5'd0);
        push(5'd3, 5'd8, 5'd0, 5'd0, 1'b0);
        tick();
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 5'd0);
        tick();

        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end
endmodule

// File: doc/int_rename_rat.md
Name: int_rename_rat

Overview:
- Single-issue integer rename stage; sits directly upstream of the integer free-register queue and consumes it.
- Keeps a speculative map table (SRAT) and a committed map table (ARAT) for 32 architectural registers.
- Maps source/destination registers to physical tags and pops a fresh tag from the free queue for each real destination.
- Returns superseded tags to the free queue at commit; on flush, restores SRAT from ARAT and pulses the queue clean.

Parameters:
PTAG_W, 5, physical tag width; equals the free queue entry width.
AREG_N, 32, number of architectural integer registers; the architectural index is 5 bits.

Ports:
Clk  in  1  clock.
Rest  in  1  reset; asynchronous, active-low.
InValid  in  1  decoded instruction valid.
InReady  out  1  stage accepts the instruction this cycle.
InRj  in  5  architectural source 1.
InRk  in  5  architectural source 2.
InRd  in  5  architectural destination.
InRdWe  in  1  instruction writes InRd.
FreeEmpty  in  1  free queue empty.
FreePreOut  in  PTAG_W  head entry of the free queue (combinational peek).
FreeRable  out  1  pop the free queue head.
FreeWable  out  1  push a released tag.
FreeDin  out  PTAG_W  released tag.
FreeClean  out  1  restore the free queue to its initial state.
OutValid  out  1  renamed instruction valid.
OutReady  in  1  downstream accepts.
OutPj  out  PTAG_W  physical source 1.
OutPk  out  PTAG_W  physical source 2.
OutPd  out  PTAG_W  new physical destination.
OutOldPd  out  PTAG_W  previous mapping of InRd; the ROB carries it to commit.
OutRdWe  out  1  effective destination write.
CmtValid  in  1  commit of one instruction.
CmtRdWe  in  1  committing instruction wrote a destination.
CmtRd  in  5  committing architectural destination.
CmtPd  in  PTAG_W  committing new tag.
CmtOldPd  in  PTAG_W  tag to release.
Flush  in  1  pipeline flush (one-cycle pulse).

Behaviour:
- Reset (Rest low, asynchronous):
  - SRAT[i] = ARAT[i] = i truncated to PTAG_W.
  - OutValid = 0.
  - OutPj/OutPk/OutPd/OutOldPd = 0; OutRdWe = 0.
  - FreeRable/FreeWable/FreeClean = 0.
- NeedAlloc = InRdWe && (InRd != 0). Register 0 always maps to tag 0, is never allocated and never released.
- InReady = !Flush && (!OutValid || OutReady) && (!NeedAlloc || !FreeEmpty).
- Fire = InValid && InReady.
- FreeRable = Fire && NeedAlloc (combinational). The allocated tag is FreePreOut in that same cycle.
- On Fire, the output register loads on the next edge with latency 1:
  - OutPj = SRAT[InRj], OutPk = SRAT[InRk], OutOldPd = SRAT[InRd], all read before this cycle's update.
  - OutPd = NeedAlloc ? FreePreOut : 0; OutRdWe = NeedAlloc.
  - SRAT[InRd] <= FreePreOut when NeedAlloc.
  - A source equal to InRd gets the old mapping.
- Output handshake:
  - OutValid holds, with stable data, while OutReady is low.
  - OutValid clears on OutReady without Fire.
  - Fire and OutReady in the same cycle give back-to-back transfer at one instruction per cycle.
- Commit, when CmtValid && CmtRdWe && CmtRd != 0:
  - ARAT[CmtRd] <= CmtPd.
  - FreeWable = 1 and FreeDin = CmtOldPd, combinationally in the same cycle.
  - FreeWable is forced to 0 while Flush is high.
- Flush:
  - FreeClean = Flush (combinational); FreeRable is forced to 0.
  - OutValid <= 0.
  - SRAT <= ARAT, where the copied ARAT includes any commit in the same cycle.
  - Flush has priority over Fire.
- Rename and commit in the same cycle update different tables and are independent. The SRAT and ARAT writes may target the same index.
- Free queue empty with NeedAlloc: InReady = 0 and no pop. Instructions with no destination still rename while the queue is empty.
- Reset asserted mid-operation discards the in-flight output and restores identity maps. No outputs glitch high during reset.

Test Plan:
- Reset, then InValid with Rd=3, Rj=1, Rk=2, InRdWe=1, FreePreOut=9 → FreeRable=1 same cycle; next cycle OutValid=1, OutPd=9, OutOldPd=3, OutPj=1, OutPk=2.
- Back-to-back: add r3←r3,r3 (allocates 9), then sub r4←r3,r0 with FreePreOut=13 → first OutPj=OutPk=3; second OutPj=9, OutPk=0, OutPd=13.
- Rd=0 with InRdWe=1 while FreeEmpty=1 → InReady=1, FreeRable=0, OutRdWe=0, OutPd=0.
- FreeEmpty=1 with Rd=5 write → InReady=0 until FreeEmpty drops. OutReady held low for 3 cycles → OutValid and data stable; InReady=0 the whole time.
- Commit Rd=3, Pd=9, OldPd=3 → FreeWable=1, FreeDin=3 same cycle; a later rename of r3 still reads 9.
- Rename r7→17, commit r3→9 and Flush in the same cycle → FreeClean=1, FreeWable=0, OutValid=0 next cycle; then SRAT[3]=9 and SRAT[7]=7.
